pcm_track_player: RTL and testbench

- Multi-track PCM sample player. Streams unsigned PCM from an external single-port BRAM (1-cycle read latency) at a sample-rate strobe.
- Supports play/pause/stop, loop mode and per-track start/length, and generates an exact progress-bar count.
- Sits between the sample-rate divider and the audio DAC/PWM stage; progress drives the display bar.
- Successor to the fixed single-song player, with parametrised widths, arbitrary track table and an explicit state machine.

---
 rtl/pcm_track_player.sv | 115 +++++++++++
 tb/tb_pcm_track_player.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_track_player.sv
// Multi-track PCM player: streams unsigned samples from a 1-cycle-latency BRAM on each
// sample tick, with play/pause/stop, looping and an exact progress-bar count.
module pcm_track_player #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 17,
  parameter int                PROG_STEPS = 140,
  parameter int                PROG_W     = 8,
  parameter logic [DATA_W-1:0] SILENCE    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] trk_start,
  input  logic [ADDR_W-1:0] trk_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] audio_data,
  output logic [PROG_W-1:0] progress,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(PROG_STEPS);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pos, start_r, len_r;
  logic [ADDR_W:0]   acc, acc_next;
  logic              do_stop, do_pause, do_play_new, do_resume, cmd_taken;
  logic              adv, at_end, wrap, finish;

  // Only the highest-priority pulse present is considered; an accepted command swallows the tick.
  always_comb begin
    do_stop     = stop;
    do_pause    = !stop && pause && (state == PLAY);
    do_play_new = !stop && !pause && play && (state != PAUSE) && (trk_len != '0);
    do_resume   = !stop && !pause && play && (state == PAUSE);
    cmd_taken   = do_stop || do_pause || do_play_new || do_resume;
    adv         = sample_tick && (state == PLAY) && !cmd_taken;
    at_end      = (pos == len_r - ADDR_W'(1));
    wrap        = adv && at_end && loop_en;
    finish      = adv && at_end && !loop_en;
    acc_next    = acc + STEP;
  end

  always_comb begin
    state_next = state;
    if (do_stop)                        state_next = IDLE;
    else if (do_pause)                  state_next = PAUSE;
    else if (do_play_new || do_resume)  state_next = PLAY;
    else if (finish)                    state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign busy = (state != IDLE);

  // Progress uses a Bresenham-style remainder so the k-th tick yields floor(k*PROG_STEPS/len).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos        <= '0;
      acc        <= '0;
      progress   <= '0;
      start_r    <= '0;
      len_r      <= '0;
      mem_addr   <= '0;
      audio_data <= SILENCE;
      done       <= 1'b0;
    end else begin
      done     <= finish;
      mem_addr <= start_r + pos;
      if (do_stop) begin
        pos        <= '0;
        acc        <= '0;
        progress   <= '0;
        audio_data <= SILENCE;
      end else if (do_pause) begin
        audio_data <= SILENCE;
      end else if (do_play_new) begin
        start_r  <= trk_start;
        len_r    <= trk_len;
        pos      <= '0;
        acc      <= '0;
        progress <= '0;
      end else if (adv) begin
        audio_data <= mem_data;
        if (wrap) begin
          pos      <= '0;
          acc      <= '0;
          progress <= '0;
        end else begin
          if (acc_next >= {1'b0, len_r}) begin
            acc      <= acc_next - {1'b0, len_r};
            progress <= progress + PROG_W'(1);
          end else begin
            acc <= acc_next;
          end
          if (!at_end) pos <= pos + ADDR_W'(1);
        end
      end else if (state != PLAY) begin
        // Last sample of a finished track lingers one cycle, then silence.
        audio_data <= SILENCE;
      end
    end
  end

endmodule

// File: tb/tb_pcm_track_player.sv
// Self-checking bench for pcm_track_player with a small BRAM model (data = addr[7:0]).
module tb_pcm_track_player;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 17;
  localparam int PROG_STEPS = 4;
  localparam int PROG_W = 8;
  localparam logic [DATA_W-1:0] SILENCE = '0;
  localparam int W = DATA_W + PROG_W;

  logic              clk, rst, sample_tick, play, pause, stop, loop_en;
  logic [ADDR_W-1:0] trk_start, trk_len, mem_addr;
  logic [DATA_W-1:0] mem_data, audio_data;
  logic [PROG_W-1:0] progress;
  logic              busy, done;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  pcm_track_player #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_STEPS(PROG_STEPS), .PROG_W(PROG_W), .SILENCE(SILENCE)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .play(play), .pause(pause), .stop(stop),
    .loop_en(loop_en), .trk_start(trk_start), .trk_len(trk_len), .mem_addr(mem_addr),
    .mem_data(mem_data), .audio_data(audio_data), .progress(progress), .busy(busy), .done(done)
  );

  // clock / reset / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem_addr[7:0];

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic t, input logic pl, input logic pa, input logic st);
    sample_tick = t; play = pl; pause = pa; stop = st;
    @(posedge clk);
    #1;
    sample_tick = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic start_track(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] l);
    trk_start = s;
    trk_len = l;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
  endtask

  // reference model
  function automatic logic [W-1:0] model(input logic [ADDR_W-1:0] s, input int pos, input int prog);
    logic [ADDR_W-1:0] a;
    a = s + ADDR_W'(pos);
    return {a[7:0], PROG_W'(prog)};
  endfunction

  // tests
  task automatic test_reset();
    checks++;
    if ({busy, done, audio_data, progress, mem_addr} !== {1'b0, 1'b0, SILENCE, {PROG_W{1'b0}}, {ADDR_W{1'b0}}}) begin
      failures++;
      $display("FAIL reset busy=%b done=%b audio=%h prog=%0d addr=%h want 0/0/%h/0/0",
               busy, done, audio_data, progress, mem_addr, SILENCE);
    end
  endtask

  task automatic test_play_once();
    loop_en = 1'b0;
    start_track(17'h100, 17'd10);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL play_busy got %b want 1", busy); end
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(model(17'h100, k - 1, (k * PROG_STEPS) / 10));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if ({audio_data, progress} !== exp_v) begin
        failures++;
        $display("FAIL play_tick%0d audio/prog got %h/%0d want %h/%0d", k, audio_data, progress, exp_v[W-1:PROG_W], exp_v[PROG_W-1:0]);
      end
      if (k < 10) step(3);
    end
    checks++;
    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL end_done done/busy got %b/%b want 1/0", done, busy); end
    step(1);
    checks++;
    if ({done, audio_data, progress} !== {1'b0, SILENCE, PROG_W'(PROG_STEPS)}) begin
      failures++;
      $display("FAIL after_end done/audio/prog got %b/%h/%0d want 0/%h/%0d", done, audio_data, progress, SILENCE, PROG_STEPS);
    end
    step(4);
    checks++;
    if (progress !== PROG_W'(PROG_STEPS)) begin failures++; $display("FAIL prog_hold got %0d want %0d", progress, PROG_STEPS); end
  endtask

  task automatic test_loop();
    int p, i, pr;
    loop_en = 1'b1;
    start_track(17'h100, 17'd10);
    for (int k = 1; k <= 25; k++) begin
      p = (k - 1) % 10;
      i = p + 1;
      pr = (i == 10) ? 0 : (i * PROG_STEPS) / 10;
      exp_q.push_back(model(17'h100, p, pr));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if ({audio_data, progress, done, busy} !== {exp_v, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL loop_tick%0d audio/prog/done/busy got %h/%0d/%b/%b want %h/%0d/0/1",
                 k, audio_data, progress, done, busy, exp_v[W-1:PROG_W], exp_v[PROG_W-1:0]);
      end
      step(3);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    loop_en = 1'b0;
  endtask

  task automatic test_pause_resume();
    start_track(17'h100, 17'd10);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(2);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({audio_data, progress, busy} !== {SILENCE, PROG_W'(2), 1'b1}) begin
        failures++;
        $display("FAIL paused%0d audio/prog/busy got %h/%0d/%b want %h/2/1", k, audio_data, progress, busy, SILENCE);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    exp_q.push_back(model(17'h100, 5, (6 * PROG_STEPS) / 10));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({audio_data, progress} !== exp_v) begin
      failures++;
      $display("FAIL resume audio/prog got %h/%0d want %h/%0d", audio_data, progress, exp_v[W-1:PROG_W], exp_v[PROG_W-1:0]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_priority();
    start_track(17'h100, 17'd10);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({busy, progress, audio_data} !== {1'b0, {PROG_W{1'b0}}, SILENCE}) begin
      failures++;
      $display("FAIL play_stop busy/prog/audio got %b/%0d/%h want 0/0/%h", busy, progress, audio_data, SILENCE);
    end
    step(1);
    checks++;
    if (mem_addr !== 17'h100) begin failures++; $display("FAIL play_stop_pos addr got %h want 00100", mem_addr); end
    start_track(17'h100, 17'd10);
    for (int k = 1; k <= 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({busy, audio_data} !== {1'b1, SILENCE}) begin
      failures++;
      $display("FAIL pause_play busy/audio got %b/%h want 1/%h", busy, audio_data, SILENCE);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    exp_q.push_back(model(17'h100, 2, (3 * PROG_STEPS) / 10));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({audio_data, progress} !== exp_v) begin
      failures++;
      $display("FAIL pause_play_resume audio/prog got %h/%0d want %h/%0d", audio_data, progress, exp_v[W-1:PROG_W], exp_v[PROG_W-1:0]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_len_zero_and_restart();
    trk_start = 17'h100;
    trk_len = 17'd0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL len_zero busy got %b want 0", busy); end
    start_track(17'h100, 17'd10);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
    end
    trk_start = 17'h200;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({busy, progress} !== {1'b1, {PROG_W{1'b0}}}) begin
      failures++;
      $display("FAIL restart busy/prog got %b/%0d want 1/0", busy, progress);
    end
    step(1);
    checks++;
    if (mem_addr !== 17'h200) begin failures++; $display("FAIL restart_addr got %h want 00200", mem_addr); end
    step(2);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(model(17'h200, k - 1, (k * PROG_STEPS) / 10));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      checks++;
      if ({audio_data, progress} !== exp_v) begin
        failures++;
        $display("FAIL restart_tick%0d audio/prog got %h/%0d want %h/%0d", k, audio_data, progress, exp_v[W-1:PROG_W], exp_v[PROG_W-1:0]);
      end
      step(1);
      checks++;
      if (mem_addr !== 17'h200 + 17'(k)) begin failures++; $display("FAIL restart_addr%0d got %h want %h", k, mem_addr, 17'h200 + 17'(k)); end
      step(2);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_tick_drop();
    start_track(17'h100, 17'd10);
    for (int k = 1; k <= 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({audio_data, progress} !== {SILENCE, PROG_W'(0)}) begin
      failures++;
      $display("FAIL tick_pause audio/prog got %h/%0d want %h/0", audio_data, progress, SILENCE);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    exp_q.push_back(model(17'h100, 2, (3 * PROG_STEPS) / 10));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({audio_data, progress} !== exp_v) begin
      failures++;
      $display("FAIL tick_dropped audio/prog got %h/%0d want %h/%0d", audio_data, progress, exp_v[W-1:PROG_W], exp_v[PROG_W-1:0]);
    end
    step(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({audio_data, progress, busy, done} !== {SILENCE, {PROG_W{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL tick_stop audio/prog/busy/done got %h/%0d/%b/%b want %h/0/0/0", audio_data, progress, busy, done, SILENCE);
    end
  endtask

  task automatic test_async_reset();
    start_track(17'h100, 17'd10);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step(3);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, audio_data, progress, mem_addr} !== {1'b0, 1'b0, SILENCE, {PROG_W{1'b0}}, {ADDR_W{1'b0}}}) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b audio=%h prog=%0d addr=%h want all reset",
               busy, done, audio_data, progress, mem_addr);
    end
    step(2);
    rst = 1'b0;
    step(2);
    checks++;
    if ({busy, progress} !== {1'b0, {PROG_W{1'b0}}}) begin
      failures++;
      $display("FAIL post_reset busy/prog got %b/%0d want 0/0", busy, progress);
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_tick = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
    trk_start = '0; trk_len = '0;
    step(3);
    test_reset();
    rst = 1'b0;
    step(2);
    test_reset();
    test_play_once();
    test_loop();
    test_pause_resume();
    test_priority();
    test_len_zero_and_restart();
    test_tick_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
